// File: rtl/placement_pkg.sv
// rtl/placement_pkg.sv - shared strip tables, FSM encodings and field widths for placement_strike_gen
package placement_pkg;

  localparam int GRID_W      = 128;
  localparam int NUM_STRIPS  = 8;
  localparam int MAX_STRIKES = 3;

  localparam int FILL_W  = 8;
  localparam int DIM_W   = 5;
  localparam int COORD_W = 7;
  localparam int IDX_W   = 3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;
  localparam logic [1:0] ST_STRIKE = 2'd3;

  typedef struct packed {
    logic [DIM_W-1:0] w;
    logic [DIM_W-1:0] h;
  } req_t;

  localparam logic [DIM_W-1:0] STRIP_H [NUM_STRIPS] =
    '{5'd4, 5'd4, 5'd6, 5'd8, 5'd8, 5'd10, 5'd12, 5'd16};

  // Row where each strip starts: running sum of the heights above it.
  localparam logic [COORD_W-1:0] STRIP_BASE [NUM_STRIPS] =
    '{7'd0, 7'd4, 7'd8, 7'd14, 7'd22, 7'd30, 7'd40, 7'd52};

endpackage

// File: rtl/placement_strike_gen_if.sv
// rtl/placement_strike_gen_if.sv - request/result bus of the placement engine
interface placement_strike_gen_if;
  import placement_pkg::*;

  logic                   req_valid;
  logic                   req_ready;
  logic [DIM_W-1:0]       req_w;
  logic [DIM_W-1:0]       req_h;
  logic                   place_valid;
  logic [COORD_W-1:0]     place_x;
  logic [COORD_W-1:0]     place_y;
  logic [IDX_W-1:0]       place_strip;
  logic                   strike_flag;
  logic                   halted;

  modport master (
    output req_valid, req_w, req_h,
    input  req_ready, place_valid, place_x, place_y, place_strip, strike_flag, halted
  );

  modport slave (
    input  req_valid, req_w, req_h,
    output req_ready, place_valid, place_x, place_y, place_strip, strike_flag, halted
  );
endinterface

// File: rtl/strip_fit_check.sv
// rtl/strip_fit_check.sv - fit test of one strip against a request, and best-candidate compare
module strip_fit_check
  import placement_pkg::*;
#(
  parameter int GRID_W = placement_pkg::GRID_W
) (
  input  logic [FILL_W-1:0] fill,
  input  logic [DIM_W-1:0]  strip_h,
  input  logic [DIM_W-1:0]  w,
  input  logic [DIM_W-1:0]  h,
  input  logic              cand_valid,
  input  logic [DIM_W-1:0]  cand_h,
  output logic              fits,
  output logic              better
);
  logic [FILL_W:0] end_pos;

  assign end_pos = {1'b0, fill} + {{(FILL_W+1-DIM_W){1'b0}}, w};
  assign fits    = (w != '0) && (h != '0) && (strip_h >= h) &&
                   (end_pos <= (FILL_W+1)'(GRID_W));
  // Strictly shorter wins, so the scan order gives ties to the lower index.
  assign better  = fits && (!cand_valid || (strip_h < cand_h));
endmodule

// File: rtl/placement_strike_gen.sv
// rtl/placement_strike_gen.sv - strip placement engine emitting strike_flag on rejects; optional STRIKE_HALT_EN
module placement_strike_gen
  import placement_pkg::*;
#(
  parameter int GRID_W     = placement_pkg::GRID_W,
  parameter int NUM_STRIPS = placement_pkg::NUM_STRIPS
) (
  input logic                  clk,
  input logic                  rst,
  placement_strike_gen_if.slave bus
);
  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  req_t               req_q, req_d;
  logic               cand_valid_q, cand_valid_d;
  logic [IDX_W-1:0]   cand_idx_q, cand_idx_d;
  logic [FILL_W-1:0]  fill_q [NUM_STRIPS];
  logic [FILL_W-1:0]  fill_d [NUM_STRIPS];
  logic [COORD_W-1:0] place_x_q, place_x_d;
  logic [COORD_W-1:0] place_y_q, place_y_d;
  logic [IDX_W-1:0]   place_strip_q, place_strip_d;
  logic               fits, better, halted_w, ready_w;

  strip_fit_check #(.GRID_W(GRID_W)) u_fit (
    .fill       (fill_q[idx_q]),
    .strip_h    (STRIP_H[idx_q]),
    .w          (req_q.w),
    .h          (req_q.h),
    .cand_valid (cand_valid_q),
    .cand_h     (STRIP_H[cand_idx_q]),
    .fits       (fits),
    .better     (better)
  );

  assign ready_w = (state_q == ST_IDLE) && !halted_w;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    req_d         = req_q;
    cand_valid_d  = cand_valid_q;
    cand_idx_d    = cand_idx_q;
    fill_d        = fill_q;
    place_x_d     = place_x_q;
    place_y_d     = place_y_q;
    place_strip_d = place_strip_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && ready_w) begin
          req_d        = '{w: bus.req_w, h: bus.req_h};
          idx_d        = '0;
          cand_valid_d = 1'b0;
          cand_idx_d   = '0;
          state_d      = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (better) begin
          cand_valid_d = 1'b1;
          cand_idx_d   = idx_q;
        end
        if (idx_q == IDX_W'(NUM_STRIPS - 1)) begin
          if (cand_valid_d) begin
            // Result fields are loaded here so they are stable during the pulse.
            state_d       = ST_COMMIT;
            place_x_d     = fill_q[cand_idx_d][COORD_W-1:0];
            place_y_d     = STRIP_BASE[cand_idx_d];
            place_strip_d = cand_idx_d;
          end else begin
            state_d = ST_STRIKE;
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_COMMIT: begin
        fill_d[cand_idx_q] = fill_q[cand_idx_q] + FILL_W'(req_q.w);
        state_d            = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      req_q         <= '0;
      cand_valid_q  <= 1'b0;
      cand_idx_q    <= '0;
      for (int i = 0; i < NUM_STRIPS; i++) fill_q[i] <= '0;
      place_x_q     <= '0;
      place_y_q     <= '0;
      place_strip_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      req_q         <= req_d;
      cand_valid_q  <= cand_valid_d;
      cand_idx_q    <= cand_idx_d;
      fill_q        <= fill_d;
      place_x_q     <= place_x_d;
      place_y_q     <= place_y_d;
      place_strip_q <= place_strip_d;
    end
  end

`ifdef STRIKE_HALT_EN
  logic [3:0] strike_cnt_q, strike_cnt_d;
  logic       halted_q, halted_d;

  always_comb begin
    strike_cnt_d = strike_cnt_q;
    halted_d     = halted_q;
    if (state_q == ST_STRIKE) begin
      strike_cnt_d = strike_cnt_q + 4'd1;
      if (strike_cnt_d >= 4'(MAX_STRIKES)) halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      strike_cnt_q <= '0;
      halted_q     <= 1'b0;
    end else begin
      strike_cnt_q <= strike_cnt_d;
      halted_q     <= halted_d;
    end
  end

  assign halted_w = halted_q;
`else
  assign halted_w = 1'b0;
`endif

  assign bus.req_ready   = ready_w;
  assign bus.place_valid = (state_q == ST_COMMIT);
  assign bus.strike_flag = (state_q == ST_STRIKE);
  assign bus.place_x     = place_x_q;
  assign bus.place_y     = place_y_q;
  assign bus.place_strip = place_strip_q;
  assign bus.halted      = halted_w;
endmodule
